// File: rtl/board_win_checker.sv
// board_win_checker
//   Decides whether either player owns a complete line on a 4x4 board.
//   On start (in IDLE) the two board vectors are snapshotted. The 10 candidate
//   lines are then scanned one per clock: rows 0-3, columns 4-7, diagonal 8,
//   anti-diagonal 9. The scan stops at the first winning line, so lower line
//   indices take priority.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          check request, only accepted in IDLE
//   gameboard      cell occupancy (1 = occupied), index = row*4 + col
//   players_cells  cell owner (0 = Player1, 1 = Player2)
//   busy           high in SCAN and DONE
//   done           one-cycle pulse, results valid from this cycle on
//   winner_valid   a winning line was found
//   winner         winning player (0 when winner_valid = 0)
//   win_line       winning line index 0-9 (0 when winner_valid = 0)
//   board_full     all 16 snapshot cells are occupied
module board_win_checker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] gameboard,
  input  logic [15:0] players_cells,
  output logic        busy,
  output logic        done,
  output logic        winner_valid,
  output logic        winner,
  output logic [3:0]  win_line,
  output logic        board_full
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      r_state;
  logic [15:0] r_board;
  logic [15:0] r_owner;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_wv;
  logic        r_winner;
  logic [3:0]  r_line;
  logic        r_full;

  // Cell indices of the line currently selected by the counter
  logic [3:0] w_c0, w_c1, w_c2, w_c3;
  logic [3:0] w_occ, w_own;
  logic       w_win;
  logic       w_last;

  always_comb begin
    w_c0 = 4'd0;
    w_c1 = 4'd0;
    w_c2 = 4'd0;
    w_c3 = 4'd0;
    case (r_cnt)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        // row r: r*4 .. r*4+3
        w_c0 = {r_cnt[1:0], 2'd0};
        w_c1 = {r_cnt[1:0], 2'd1};
        w_c2 = {r_cnt[1:0], 2'd2};
        w_c3 = {r_cnt[1:0], 2'd3};
      end
      4'd4, 4'd5, 4'd6, 4'd7: begin
        // column c = line-4: c, c+4, c+8, c+12
        w_c0 = {2'd0, r_cnt[1:0]};
        w_c1 = {2'd1, r_cnt[1:0]};
        w_c2 = {2'd2, r_cnt[1:0]};
        w_c3 = {2'd3, r_cnt[1:0]};
      end
      4'd8: begin
        w_c0 = 4'd0;
        w_c1 = 4'd5;
        w_c2 = 4'd10;
        w_c3 = 4'd15;
      end
      4'd9: begin
        w_c0 = 4'd3;
        w_c1 = 4'd6;
        w_c2 = 4'd9;
        w_c3 = 4'd12;
      end
      default: ;
    endcase
  end

  assign w_occ  = {r_board[w_c3], r_board[w_c2], r_board[w_c1], r_board[w_c0]};
  assign w_own  = {r_owner[w_c3], r_owner[w_c2], r_owner[w_c1], r_owner[w_c0]};
  assign w_win  = (&w_occ) && ((&w_own) || ~(|w_own));
  assign w_last = (r_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_board  <= 16'd0;
      r_owner  <= 16'd0;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wv     <= 1'b0;
      r_winner <= 1'b0;
      r_line   <= 4'd0;
      r_full   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_board  <= gameboard;
            r_owner  <= players_cells;
            r_cnt    <= 4'd0;
            r_wv     <= 1'b0;
            r_winner <= 1'b0;
            r_line   <= 4'd0;
            r_full   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (w_win || w_last) begin
            // Results and done are registered together so they appear in the same cycle
            r_wv     <= w_win;
            r_winner <= w_win & w_own[0];
            r_line   <= w_win ? r_cnt : 4'd0;
            r_full   <= &r_board;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign winner_valid = r_wv;
  assign winner       = r_winner;
  assign win_line     = r_line;
  assign board_full   = r_full;

endmodule

// File: tb/tb_board_win_checker.sv
module tb_board_win_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] gameboard;
  logic [15:0] players_cells;
  logic        busy, done, winner_valid, winner, board_full;
  logic [3:0]  win_line;

  int total = 0;
  int bad   = 0;

  board_win_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .gameboard    (gameboard),
    .players_cells(players_cells),
    .busy         (busy),
    .done         (done),
    .winner_valid (winner_valid),
    .winner       (winner),
    .win_line     (win_line),
    .board_full   (board_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cell k (0..3) of line l, from the line definitions
  function automatic int cell_of(input int l, input int k);
    if (l < 4)       return l * 4 + k;
    else if (l < 8)  return (l - 4) + 4 * k;
    else if (l == 8) return 5 * k;
    else             return 3 + 3 * k;
  endfunction

  // First winning line in index order, or none
  task automatic ref_model(input logic [15:0] gb, input logic [15:0] pc,
                           output bit wv, output bit w, output int ln);
    wv = 0; w = 0; ln = 0;
    for (int l = 0; l < 10; l++) begin
      int occ, own;
      occ = 0; own = 0;
      for (int k = 0; k < 4; k++) begin
        occ += gb[cell_of(l, k)];
        own += pc[cell_of(l, k)];
      end
      if (!wv && occ == 4 && (own == 0 || own == 4)) begin
        wv = 1; w = (own == 4); ln = l;
      end
    end
  endtask

  // mode: 0 = hold inputs during scan, 1 = random inputs, 2 = drive 000F/0000
  task automatic run(input string tag, input logic [15:0] gb, input logic [15:0] pc, input int mode);
    bit wv, w;
    int ln, lat, n;
    bit busy_ok;
    ref_model(gb, pc, wv, w, ln);
    lat = wv ? 2 + ln : 11;
    @(negedge clk);
    gameboard = gb; players_cells = pc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_ok = 1;
    while (!done && n < 30) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (mode == 1) begin gameboard = 16'($urandom); players_cells = 16'($urandom); end
      if (mode == 2) begin gameboard = 16'h000F; players_cells = 16'h0000; end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_scan"}, busy_ok, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_wv"}, winner_valid, wv);
    chk({tag, "_winner"}, winner, w);
    chk({tag, "_line"}, win_line, ln);
    chk({tag, "_full"}, board_full, &gb);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_hold"}, {winner_valid, winner, win_line, board_full}, {wv, w, 4'(ln), &gb});
  endtask

  initial begin
    int dones;
    rst_n = 1'b1; start = 1'b0; gameboard = 16'h0; players_cells = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", {busy, done, winner_valid, winner, win_line, board_full}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run("empty",      16'h0000, 16'h0000, 0);
    run("p1_row0",    16'h000F, 16'h0000, 0);
    run("p2_col2",    16'h4444, 16'h4444, 0);
    run("p2_anti",    16'h1248, 16'h1248, 0);
    run("mixed_row0", 16'h000F, 16'h0001, 0);
    run("full_none",  16'hFFFF, 16'hC3C3, 2);
    run("p2_diag",    16'h8421, 16'h8421, 1);
    run("two_wins",   16'hF00F, 16'hF000, 0);

    // start pulse during SCAN must not create an extra result
    @(negedge clk);
    gameboard = 16'h0000; players_cells = 16'h0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("start_in_scan_dones", dones, 1);

    // reset in the middle of an empty-board scan
    @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;   // cycle T+1
    @(negedge clk); @(negedge clk); @(negedge clk); // cycle T+4
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", {busy, done, winner_valid, winner, win_line, board_full}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    chk("post_reset_quiet", dones, 0);
    run("after_reset", 16'h000F, 16'h0000, 0);

    // randomized boards, some with a planted line, scrambled inputs during scan
    for (int t = 0; t < 40; t++) begin
      logic [15:0] gb, pc;
      int l;
      gb = 16'($urandom);
      pc = 16'($urandom);
      if (t % 5 == 0) gb = 16'hFFFF;
      if ($urandom_range(0, 1) == 1) begin
        bit o;
        l = $urandom_range(0, 9);
        o = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
          gb[cell_of(l, k)] = 1'b1;
          pc[cell_of(l, k)] = o;
        end
      end
      run($sformatf("rnd%0d", t), gb, pc, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
